pll_reset_ctrl: RTL and testbench

Reset and lock supervisor that drives the iCE40 PLL's active-low RESETB and consumes its LOCK output. Runs in the 16 MHz reference-clock domain. Holds the PLL in reset at start-up and waits for a stable lock. Releases the system reset for PLL-clocked logic, and re-sequences the PLL on lock loss or lock timeout, entering a latched fault state after a bounded number of retries.

---
 rtl/pll_reset_ctrl_if.sv | 21 ++
 rtl/pll_reset_ctrl.sv | 142 ++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_ctrl_if.sv
// Signal bundle between the PLL supervisor and the iCE40 PLL / PLL-domain logic.
// master: the supervisor; slave: the PLL and reset consumers.
interface pll_reset_ctrl_if;
   logic       LOCK;
   logic       PLL_RESETB;
   logic       SYS_RESET;
   logic       LOCKED;
   logic       FAULT;
   logic [3:0] RETRY_COUNT;
   logic [7:0] LOSS_COUNT;

   modport master (
      input  LOCK,
      output PLL_RESETB, SYS_RESET, LOCKED, FAULT, RETRY_COUNT, LOSS_COUNT
   );

   modport slave (
      output LOCK,
      input  PLL_RESETB, SYS_RESET, LOCKED, FAULT, RETRY_COUNT, LOSS_COUNT
   );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset/lock supervisor in the reference-clock domain: hold, wait for lock, qualify, run, retry, fault.
// Optional lock-loss event counter enabled by defining PLL_RESET_CTRL_LOSS_COUNT_EN.
module pll_reset_ctrl #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int STABLE_CYCLES = 256,
   parameter int MAX_RETRIES   = 3
) (
   input  logic             REFERENCECLK,
   input  logic             RESET,
   pll_reset_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_HOLD, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAULT
   } state_t;

   localparam logic [15:0] C_HOLD_LAST   = 16'(RESET_CYCLES - 1);
   localparam logic [15:0] C_WAIT_LAST   = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] C_STABLE_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [3:0]  C_MAX_RETRY   = 4'(MAX_RETRIES);

   state_t      r_state, w_state_nxt;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic [3:0]  r_retry, w_retry_nxt;
   logic        r_lock_meta, r_lock_s;
   logic        r_pll_resetb, r_sys_reset, r_locked, r_fault;

   // LOCK comes from the PLL output, asynchronous to this clock
   always_ff @(posedge REFERENCECLK) begin
      if (RESET) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= bus.LOCK;
         r_lock_s    <= r_lock_meta;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_retry_nxt = r_retry;
      case (r_state)
         S_HOLD: begin
            if (r_cnt == C_HOLD_LAST) begin
               w_state_nxt = S_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         S_WAIT_LOCK: begin
            if (r_lock_s) begin
               w_state_nxt = S_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == C_WAIT_LAST) begin
               w_cnt_nxt = '0;
               if (r_retry == C_MAX_RETRY) begin
                  w_state_nxt = S_FAULT;
               end else begin
                  w_state_nxt = S_HOLD;
                  w_retry_nxt = r_retry + 4'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         S_STABLE: begin
            // a lock glitch restarts qualification without spending a retry
            if (!r_lock_s) begin
               w_state_nxt = S_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt == C_STABLE_LAST) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         S_RUN: begin
            if (!r_lock_s) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
            end
         end
         S_FAULT: ;
         default: begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // outputs decode the next state so they move on the same edge as the state
   always_ff @(posedge REFERENCECLK) begin
      if (RESET) begin
         r_state      <= S_HOLD;
         r_cnt        <= '0;
         r_retry      <= '0;
         r_pll_resetb <= 1'b0;
         r_sys_reset  <= 1'b1;
         r_locked     <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_retry      <= w_retry_nxt;
         r_pll_resetb <= (w_state_nxt == S_WAIT_LOCK) || (w_state_nxt == S_STABLE) ||
                         (w_state_nxt == S_RUN);
         r_sys_reset  <= (w_state_nxt != S_RUN);
         r_locked     <= (w_state_nxt == S_RUN);
         r_fault      <= (w_state_nxt == S_FAULT);
      end
   end

`ifdef PLL_RESET_CTRL_LOSS_COUNT_EN
   logic [7:0] r_loss;
   logic       w_lost;

   assign w_lost = (r_state == S_RUN) && !r_lock_s;

   always_ff @(posedge REFERENCECLK) begin
      if (RESET)
         r_loss <= '0;
      else if (w_lost && (r_loss != 8'hFF))
         r_loss <= r_loss + 8'd1;
   end

   assign bus.LOSS_COUNT = r_loss;
`else
   assign bus.LOSS_COUNT = '0;
`endif

   assign bus.PLL_RESETB  = r_pll_resetb;
   assign bus.SYS_RESET   = r_sys_reset;
   assign bus.LOCKED      = r_locked;
   assign bus.FAULT       = r_fault;
   assign bus.RETRY_COUNT = r_retry;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: default-parameter instance for the timed scenarios, a short-parameter
// instance for lock-loss saturation; both shadowed every cycle by a phase/age reference model.
module tb_pll_reset_ctrl;

`ifdef PLL_RESET_CTRL_LOSS_COUNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   localparam int P_RC [2] = '{16, 2};
   localparam int P_LT [2] = '{4096, 8};
   localparam int P_SC [2] = '{256, 4};
   localparam int P_MR [2] = '{3, 1};

   localparam int PH_HOLD = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAULT = 4;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pll_reset_ctrl_if ifa ();
   pll_reset_ctrl_if ifb ();

   pll_reset_ctrl dut_a (.REFERENCECLK(clk), .RESET(rst_a), .bus(ifa.master));

   pll_reset_ctrl #(
      .RESET_CYCLES(2), .LOCK_TIMEOUT(8), .STABLE_CYCLES(4), .MAX_RETRIES(1)
   ) dut_b (.REFERENCECLK(clk), .RESET(rst_b), .bus(ifb.master));

   wire logic [15:0] w_got_a = {ifa.PLL_RESETB, ifa.SYS_RESET, ifa.LOCKED, ifa.FAULT,
                                ifa.RETRY_COUNT, ifa.LOSS_COUNT};
   wire logic [15:0] w_got_b = {ifb.PLL_RESETB, ifb.SYS_RESET, ifb.LOCKED, ifb.FAULT,
                                ifb.RETRY_COUNT, ifb.LOSS_COUNT};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: phase plus cycles spent in it; lock seen two samples late
   int m_ph [2], m_age [2], m_retry [2], m_loss [2];
   bit m_d1 [2], m_d2 [2], m_ok [2];

   task automatic model_step(input int i, input bit rst, input bit lk);
      bit ls;
      ls = m_d2[i];
      if (rst) begin
         m_ph[i] = PH_HOLD; m_age[i] = 0; m_retry[i] = 0; m_loss[i] = 0;
         m_d1[i] = 0; m_d2[i] = 0; m_ok[i] = 1;
         return;
      end
      m_d2[i] = m_d1[i];
      m_d1[i] = lk;
      case (m_ph[i])
         PH_HOLD: begin
            m_age[i]++;
            if (m_age[i] == P_RC[i]) begin m_ph[i] = PH_WAIT; m_age[i] = 0; end
         end
         PH_WAIT: begin
            if (ls) begin
               m_ph[i] = PH_STABLE; m_age[i] = 0;
            end else begin
               m_age[i]++;
               if (m_age[i] == P_LT[i]) begin
                  m_age[i] = 0;
                  if (m_retry[i] == P_MR[i]) m_ph[i] = PH_FAULT;
                  else begin m_retry[i]++; m_ph[i] = PH_HOLD; end
               end
            end
         end
         PH_STABLE: begin
            if (!ls) begin
               m_ph[i] = PH_WAIT; m_age[i] = 0;
            end else begin
               m_age[i]++;
               if (m_age[i] == P_SC[i]) m_ph[i] = PH_RUN;
            end
         end
         PH_RUN: begin
            if (!ls) begin
               m_ph[i] = PH_HOLD; m_age[i] = 0; m_retry[i] = 0;
               if (LOSS_EN && m_loss[i] < 255) m_loss[i]++;
            end
         end
         default: ;
      endcase
   endtask

   function automatic logic [15:0] m_exp(input int i);
      logic pll;
      pll = (m_ph[i] == PH_WAIT) || (m_ph[i] == PH_STABLE) || (m_ph[i] == PH_RUN);
      return {pll, m_ph[i] != PH_RUN, m_ph[i] == PH_RUN, m_ph[i] == PH_FAULT,
              4'(m_retry[i]), 8'(m_loss[i])};
   endfunction

   always @(posedge clk) begin
      model_step(0, rst_a, ifa.LOCK);
      model_step(1, rst_b, ifb.LOCK);
   end

   always @(negedge clk) begin
      if (m_ok[0]) chk("cyc_a", 32'(w_got_a), 32'(m_exp(0)));
      if (m_ok[1]) chk("cyc_b", 32'(w_got_b), 32'(m_exp(1)));
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // leaves the bench just after "edge 0", the last edge that still sampled RESET high
   task automatic release_rst(input int i);
      if (i == 0) rst_a = 1'b1; else rst_b = 1'b1;
      step(3);
      chk(i == 0 ? "rst_a" : "rst_b", 32'(i == 0 ? w_got_a : w_got_b), 32'h4000);
      if (i == 0) rst_a = 1'b0; else rst_b = 1'b0;
   endtask

   initial begin
      int k;
      ifa.LOCK = 1'b0;
      ifb.LOCK = 1'b0;

      // bring-up with lock arriving 100 cycles after PLL_RESETB rises
      release_rst(0);
      step(15);  chk("pll_low_e15", ifa.PLL_RESETB, 0);
      step(1);   chk("pll_rise_e16", ifa.PLL_RESETB, 1);
      step(100); ifa.LOCK = 1'b1;
      step(258); chk("sys_before_run", ifa.SYS_RESET, 1);
      step(1);   chk("sys_fall_run", ifa.SYS_RESET, 0);
      chk("locked_run", ifa.LOCKED, 1);
      chk("retry_run", ifa.RETRY_COUNT, 0);

      // lock loss in RUN
      step(10);  ifa.LOCK = 1'b0;
      step(2);   chk("loss_still_locked", ifa.LOCKED, 1);
      step(1);   chk("loss_sys", ifa.SYS_RESET, 1);
      chk("loss_pll", ifa.PLL_RESETB, 0);
      chk("loss_retry", ifa.RETRY_COUNT, 0);
      chk("loss_count", ifa.LOSS_COUNT, LOSS_EN ? 1 : 0);
      ifa.LOCK = 1'b1;
      k = 0;
      while (!ifa.LOCKED && k < 400) begin step(1); k++; end
      chk("relock", ifa.LOCKED, 1);

      // one-cycle lock glitch at STABLE cnt 200
      release_rst(0);
      step(217); ifa.LOCK = 1'b0;
      step(1);   ifa.LOCK = 1'b1;
      step(2);   chk("glitch_pll", ifa.PLL_RESETB, 1);
      step(256); chk("glitch_not_run", ifa.LOCKED, 0);
      step(1);   chk("glitch_run", ifa.LOCKED, 1);
      chk("glitch_retry", ifa.RETRY_COUNT, 0);

      // RESET pulse mid-WAIT_LOCK with two retries spent
      ifa.LOCK = 1'b0;
      release_rst(0);
      step(8300); chk("mid_retry2", ifa.RETRY_COUNT, 2);
      rst_a = 1'b1;
      step(1);   chk("mid_rst_pll", ifa.PLL_RESETB, 0);
      chk("mid_rst_retry", ifa.RETRY_COUNT, 0);
      rst_a = 1'b0;
      step(15);  chk("restart_pll_low", ifa.PLL_RESETB, 0);
      step(1);   chk("restart_pll_rise", ifa.PLL_RESETB, 1);

      // lock never arrives: retries then latched fault
      release_rst(0);
      step(4111); chk("retry0", ifa.RETRY_COUNT, 0);
      step(1);    chk("retry1", ifa.RETRY_COUNT, 1);
      step(4111); chk("retry1_hold", ifa.RETRY_COUNT, 1);
      step(1);    chk("retry2", ifa.RETRY_COUNT, 2);
      step(4112); chk("retry3", ifa.RETRY_COUNT, 3);
      step(4111); chk("fault_pre", ifa.FAULT, 0);
      step(1);    chk("fault_e16448", ifa.FAULT, 1);
      chk("fault_pll", ifa.PLL_RESETB, 0);
      ifa.LOCK = 1'b1;
      step(50);   chk("fault_latched", ifa.FAULT, 1);

      // random lock activity on the default instance
      release_rst(0);
      for (int n = 0; n < 4000; n++) begin
         step(1);
         if ($urandom_range(0, 299) == 0) ifa.LOCK = ~ifa.LOCK;
         if ($urandom_range(0, 2999) == 0) begin rst_a = 1'b1; step(1); rst_a = 1'b0; end
      end
      rst_a = 1'b1;

      // short instance: 300 lock-loss events
      ifb.LOCK = 1'b1;
      release_rst(1);
      for (int e = 0; e < 300; e++) begin
         k = 0;
         while (!ifb.LOCKED && k < 50) begin step(1); k++; end
         if (!ifb.LOCKED) begin chk("b_lock_wait", 0, 1); break; end
         ifb.LOCK = 1'b0;
         step(3);
         ifb.LOCK = 1'b1;
      end
      step(1);
      chk("b_loss_sat", ifb.LOSS_COUNT, LOSS_EN ? 255 : 0);

      // random lock activity on the short instance, exercising retries and fault
      for (int n = 0; n < 2000; n++) begin
         step(1);
         if ($urandom_range(0, 4) == 0) ifb.LOCK = ~ifb.LOCK;
         if ($urandom_range(0, 499) == 0) begin rst_b = 1'b1; step(1); rst_b = 1'b0; end
      end

      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
